// File: rtl/game_control_if.sv
// Phase/paddle bundle between the game-flow controller and the pong datapath.
interface game_control_if;
    logic       game_clk;
    logic       ready_sig;
    logic       start_sig;
    logic       play_sig;
    logic       pause_sig;
    logic       left_sig;
    logic       right_sig;
    logic [1:0] lives;
    logic       game_over;
    logic       sig_dead;

    modport master (
        output game_clk, ready_sig, start_sig, play_sig, pause_sig,
               left_sig, right_sig, lives, game_over,
        input  sig_dead
    );

    modport slave (
        input  game_clk, ready_sig, start_sig, play_sig, pause_sig,
               left_sig, right_sig, lives, game_over,
        output sig_dead
    );
endinterface

// File: rtl/game_control.sv
// Pong game-flow controller: key synchronizers, READY/START/PLAY/PAUSE/DEAD/OVER
// state machine, movement tick divider and lives counter. All outputs registered.
module game_control #(
    parameter int TICK_DIV   = 500000,
    parameter int LIVES      = 3,
    parameter int DEAD_TICKS = 50
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_start_n,
    input  logic          key_pause_n,
    input  logic          key_left_n,
    input  logic          key_right_n,
    game_control_if.master gc
);
    localparam int             CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  DIV_MAX    = CW'(TICK_DIV - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
    localparam logic [7:0]     DEAD_MAX   = 8'(DEAD_TICKS);

    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_PAUSE = 2;
    localparam int K_START = 3;

    typedef enum logic [2:0] {
        ST_READY,
        ST_START,
        ST_PLAY,
        ST_PAUSE,
        ST_DEAD,
        ST_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    s1_q, s1_d, s2_q, s2_d, h_q, h_d;
    logic [3:0]    key_ev;
    logic [CW-1:0] div_q, div_d;
    logic [7:0]    tick_q, tick_d;
    logic [7:0]    tick_inc;
    logic [1:0]    lives_q, lives_d;
    logic          game_clk_q, game_clk_d;
    logic          ready_q, ready_d;
    logic          start_q, start_d;
    logic          play_q, play_d;
    logic          pause_q, pause_d;
    logic          left_q, left_d;
    logic          right_q, right_d;
    logic          over_q, over_d;

    // Press event fires once per falling edge of the synchronized key.
    always_comb begin
        s1_d     = {key_start_n, key_pause_n, key_left_n, key_right_n};
        s2_d     = s1_q;
        h_d      = s2_q;
        key_ev   = h_q & ~s2_q;
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        tick_d     = tick_q;
        tick_inc   = tick_q + 8'd1;
        game_clk_d = (div_q == DIV_MAX);
        div_d      = game_clk_d ? '0 : div_q + CW'(1);

        unique case (state_q)
            ST_READY: begin
                if (key_ev[K_START]) state_d = ST_START;
            end
            ST_START: state_d = ST_PLAY;
            ST_PLAY: begin
                if (gc.sig_dead) begin
                    state_d = ST_DEAD;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    tick_d  = 8'd0;
                end else if (key_ev[K_PAUSE]) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (key_ev[K_PAUSE]) state_d = ST_PLAY;
            end
            // Exit lands on the same edge that registers the final tick pulse.
            ST_DEAD: begin
                if (game_clk_d) begin
                    tick_d = tick_inc;
                    if (tick_inc == DEAD_MAX)
                        state_d = (lives_q != 2'd0) ? ST_READY : ST_OVER;
                end
            end
            ST_OVER: begin
                if (key_ev[K_START]) begin
                    lives_d = LIVES_INIT;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase

        ready_d = (state_d == ST_READY);
        start_d = (state_d == ST_START);
        play_d  = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
        pause_d = (state_d == ST_PAUSE);
        over_d  = (state_d == ST_OVER);
        left_d  = (state_d == ST_PLAY) && !s2_q[K_LEFT] && s2_q[K_RIGHT];
        right_d = (state_d == ST_PLAY) && !s2_q[K_RIGHT] && s2_q[K_LEFT];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_READY;
            s1_q       <= 4'hF;
            s2_q       <= 4'hF;
            h_q        <= 4'hF;
            div_q      <= '0;
            tick_q     <= 8'd0;
            lives_q    <= LIVES_INIT;
            game_clk_q <= 1'b0;
            ready_q    <= 1'b1;
            start_q    <= 1'b0;
            play_q     <= 1'b0;
            pause_q    <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            h_q        <= h_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            lives_q    <= lives_d;
            game_clk_q <= game_clk_d;
            ready_q    <= ready_d;
            start_q    <= start_d;
            play_q     <= play_d;
            pause_q    <= pause_d;
            left_q     <= left_d;
            right_q    <= right_d;
            over_q     <= over_d;
        end
    end

    assign gc.game_clk  = game_clk_q;
    assign gc.ready_sig = ready_q;
    assign gc.start_sig = start_q;
    assign gc.play_sig  = play_q;
    assign gc.pause_sig = pause_q;
    assign gc.left_sig  = left_q;
    assign gc.right_sig = right_q;
    assign gc.lives     = lives_q;
    assign gc.game_over = over_q;
endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with a short tick divider and two lives.
module tb_game_control;
    localparam int TICK_DIV   = 4;
    localparam int LIVES      = 2;
    localparam int DEAD_TICKS = 2;

    logic clk = 1'b0;
    logic reset;
    logic key_start_n = 1'b1;
    logic key_pause_n = 1'b1;
    logic key_left_n  = 1'b1;
    logic key_right_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    game_control_if gc();

    game_control #(
        .TICK_DIV  (TICK_DIV),
        .LIVES     (LIVES),
        .DEAD_TICKS(DEAD_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_start_n(key_start_n),
        .key_pause_n(key_pause_n),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .gc         (gc)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Settle, then hold the key low long enough for its event to change state.
    task automatic press(input int k);
        step(3);
        case (k)
            0: key_start_n = 1'b0;
            default: key_pause_n = 1'b0;
        endcase
        step(3);
        key_start_n = 1'b1;
        key_pause_n = 1'b1;
    endtask

    task automatic start_game();
        press(0);
        step(1);
    endtask

    task automatic wait_exit(output int pulses, output bit exited, output bit clk_at_exit);
        pulses      = 0;
        exited      = 1'b0;
        clk_at_exit = 1'b0;
        for (int i = 0; i < 40 && !exited; i++) begin
            step(1);
            if (gc.game_clk) pulses++;
            if (gc.ready_sig || gc.game_over) begin
                exited      = 1'b1;
                clk_at_exit = gc.game_clk;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({gc.ready_sig, gc.start_sig, gc.play_sig, gc.pause_sig, gc.left_sig,
             gc.right_sig, gc.game_clk, gc.game_over} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 10000000",
                     {gc.ready_sig, gc.start_sig, gc.play_sig, gc.pause_sig, gc.left_sig,
                      gc.right_sig, gc.game_clk, gc.game_over});
        end
        n_checks++;
        if (gc.lives !== 2'(LIVES)) begin
            n_fail++;
            $display("FAIL reset_lives got %0d want %0d", gc.lives, LIVES);
        end
        step(2);
        reset = 1'b1;
        step(1);
        n_checks++;
        if (gc.ready_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release got %b want 1", gc.ready_sig);
        end
    endtask

    task automatic test_start_game();
        int extra = 0;
        key_start_n = 1'b0;
        step(2);
        n_checks++;
        if (gc.start_sig !== 1'b0 || gc.ready_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL start_early got start=%b ready=%b want 0/1", gc.start_sig, gc.ready_sig);
        end
        step(1);
        n_checks++;
        if (gc.start_sig !== 1'b1 || gc.ready_sig !== 1'b0 || gc.play_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse got start=%b ready=%b play=%b want 1/0/0",
                     gc.start_sig, gc.ready_sig, gc.play_sig);
        end
        step(1);
        n_checks++;
        if (gc.start_sig !== 1'b0 || gc.play_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL play_rise got start=%b play=%b want 0/1", gc.start_sig, gc.play_sig);
        end
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (gc.start_sig) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL start_no_repeat got %0d extra pulses want 0", extra);
        end
        key_start_n = 1'b1;
    endtask

    task automatic test_tick();
        int count = 0;
        int last  = -1;
        int bad_gap = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (gc.game_clk) begin
                if (last >= 0 && (i - last) != TICK_DIV) bad_gap++;
                last = i;
                count++;
            end
        end
        n_checks++;
        if (count !== 5) begin
            n_fail++;
            $display("FAIL tick_count got %0d want 5", count);
        end
        n_checks++;
        if (bad_gap !== 0) begin
            n_fail++;
            $display("FAIL tick_period got %0d bad gaps want 0", bad_gap);
        end
    endtask

    task automatic test_paddles();
        step(3);
        key_left_n = 1'b0;
        step(3);
        n_checks++;
        if (gc.left_sig !== 1'b1 || gc.right_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL left_held got L=%b R=%b want 1/0", gc.left_sig, gc.right_sig);
        end
        key_right_n = 1'b0;
        step(3);
        n_checks++;
        if (gc.left_sig !== 1'b0 || gc.right_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL both_held got L=%b R=%b want 0/0", gc.left_sig, gc.right_sig);
        end
        key_right_n = 1'b1;
        step(3);
        n_checks++;
        if (gc.left_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL left_again got L=%b want 1", gc.left_sig);
        end
        press(1);
        n_checks++;
        if (gc.pause_sig !== 1'b1 || gc.play_sig !== 1'b1 || gc.left_sig !== 1'b0
            || gc.right_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter got P=%b play=%b L=%b R=%b want 1/1/0/0",
                     gc.pause_sig, gc.play_sig, gc.left_sig, gc.right_sig);
        end
        press(1);
        n_checks++;
        if (gc.pause_sig !== 1'b0 || gc.play_sig !== 1'b1 || gc.left_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_exit got P=%b play=%b L=%b want 0/1/1",
                     gc.pause_sig, gc.play_sig, gc.left_sig);
        end
        key_left_n = 1'b1;
        step(3);
        n_checks++;
        if (gc.left_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL left_release got L=%b want 0", gc.left_sig);
        end
    endtask

    task automatic test_lives();
        int pulses;
        bit exited, clk_at_exit;
        gc.sig_dead = 1'b1;
        step(1);
        gc.sig_dead = 1'b0;
        n_checks++;
        if (gc.play_sig !== 1'b0 || gc.ready_sig !== 1'b0 || gc.lives !== 2'd1) begin
            n_fail++;
            $display("FAIL dead_enter got play=%b ready=%b lives=%0d want 0/0/1",
                     gc.play_sig, gc.ready_sig, gc.lives);
        end
        wait_exit(pulses, exited, clk_at_exit);
        n_checks++;
        if (!exited || gc.ready_sig !== 1'b1 || pulses !== DEAD_TICKS || clk_at_exit !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_exit got exited=%b ready=%b pulses=%0d tick=%b want 1/1/%0d/1",
                     exited, gc.ready_sig, pulses, clk_at_exit, DEAD_TICKS);
        end
        start_game();
        n_checks++;
        if (gc.play_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL replay got play=%b want 1", gc.play_sig);
        end
        gc.sig_dead = 1'b1;
        step(1);
        gc.sig_dead = 1'b0;
        wait_exit(pulses, exited, clk_at_exit);
        n_checks++;
        if (!exited || gc.game_over !== 1'b1 || gc.ready_sig !== 1'b0 || gc.lives !== 2'd0) begin
            n_fail++;
            $display("FAIL game_over got exited=%b over=%b ready=%b lives=%0d want 1/1/0/0",
                     exited, gc.game_over, gc.ready_sig, gc.lives);
        end
        press(0);
        n_checks++;
        if (gc.ready_sig !== 1'b1 || gc.game_over !== 1'b0 || gc.lives !== 2'(LIVES)
            || gc.start_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL restart got ready=%b over=%b lives=%0d start=%b want 1/0/%0d/0",
                     gc.ready_sig, gc.game_over, gc.lives, gc.start_sig, LIVES);
        end
    endtask

    task automatic test_precedence();
        int pulses;
        bit exited, clk_at_exit;
        start_game();
        step(3);
        key_pause_n = 1'b0;
        step(2);
        gc.sig_dead = 1'b1;
        step(1);
        gc.sig_dead = 1'b0;
        key_pause_n = 1'b1;
        n_checks++;
        if (gc.play_sig !== 1'b0 || gc.pause_sig !== 1'b0 || gc.lives !== 2'd1) begin
            n_fail++;
            $display("FAIL dead_beats_pause got play=%b pause=%b lives=%0d want 0/0/1",
                     gc.play_sig, gc.pause_sig, gc.lives);
        end
        wait_exit(pulses, exited, clk_at_exit);
        n_checks++;
        if (!exited || gc.ready_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL prec_exit got exited=%b ready=%b want 1/1", exited, gc.ready_sig);
        end
        start_game();
        press(1);
        gc.sig_dead = 1'b1;
        step(2);
        gc.sig_dead = 1'b0;
        n_checks++;
        if (gc.pause_sig !== 1'b1 || gc.play_sig !== 1'b1 || gc.lives !== 2'd1) begin
            n_fail++;
            $display("FAIL dead_in_pause got pause=%b play=%b lives=%0d want 1/1/1",
                     gc.pause_sig, gc.play_sig, gc.lives);
        end
        press(0);
        n_checks++;
        if (gc.pause_sig !== 1'b1 || gc.start_sig !== 1'b0 || gc.ready_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_pause got pause=%b start=%b ready=%b want 1/0/0",
                     gc.pause_sig, gc.start_sig, gc.ready_sig);
        end
    endtask

    task automatic test_reset_mid();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (gc.ready_sig !== 1'b1 || gc.play_sig !== 1'b0 || gc.pause_sig !== 1'b0
            || gc.lives !== 2'(LIVES) || gc.game_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got ready=%b play=%b pause=%b lives=%0d tick=%b want 1/0/0/%0d/0",
                     gc.ready_sig, gc.play_sig, gc.pause_sig, gc.lives, gc.game_clk, LIVES);
        end
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        gc.sig_dead = 1'b0;
        test_reset();
        test_start_game();
        test_tick();
        test_paddles();
        test_lives();
        test_precedence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
